// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/load controller sitting between the debounced switches /
// instruction receiver and the CPU core.
//
// Owns the instruction-memory write address during program load and produces
// the one-cycle CPU advance pulse (o_control_en), either free-running in RUN
// or one per step release in PAUSE.
//
// Ports:
//   i_clk        master clock
//   i_rst        asynchronous reset, active-high
//   i_run_btn    debounced run switch (acts on release)
//   i_step_btn   debounced step switch (acts on release)
//   i_rx_dv      one-cycle strobe: received instruction valid
//   i_halt       CPU loop/finish flag
//   i_rate_sel   RUN period = 2^(PULSE_WIDTH - i_rate_sel) cycles
//   o_on         high in every state except LOAD
//   o_state      LOAD=00, RUN=01, PAUSE=10, HALT=11
//   o_instr_addr instruction write address
//   o_instr_we   instruction write enable (combinational with i_rx_dv)
//   o_control_en one-cycle CPU advance pulse (registered)
//   o_mem_full   last address written; further writes dropped
//   o_halted     state == HALT
module cpu_run_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int PULSE_WIDTH = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_run_btn,
    input  logic                  i_step_btn,
    input  logic                  i_rx_dv,
    input  logic                  i_halt,
    input  logic [1:0]            i_rate_sel,
    output logic                  o_on,
    output logic [1:0]            o_state,
    output logic [ADDR_WIDTH-1:0] o_instr_addr,
    output logic                  o_instr_we,
    output logic                  o_control_en,
    output logic                  o_mem_full,
    output logic                  o_halted
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_MAX = '1;
    localparam logic [PULSE_WIDTH-1:0] CNT_ONES = '1;

    state_t                  state_q, state_d;
    logic                    run_prev_q, step_prev_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    full_q, full_d;
    logic [PULSE_WIDTH-1:0]  cnt_q, cnt_d;
    logic                    en_q, en_d;

    logic                    run_rel, step_rel;
    logic                    we;
    logic [PULSE_WIDTH-1:0]  rate_mask;
    logic                    terminal;

    assign run_rel  = run_prev_q & ~i_run_btn;
    assign step_rel = step_prev_q & ~i_step_btn;

    // Terminal count looks only at the low (PULSE_WIDTH - i_rate_sel) bits,
    // so a rate change takes effect without disturbing the counter.
    assign rate_mask = CNT_ONES >> i_rate_sel;
    assign terminal  = (cnt_q & rate_mask) == rate_mask;

    assign we = i_rx_dv & (state_q == ST_LOAD) & ~full_q;

    // Next state and advance pulse. Priority: run_rel > i_halt > step_rel.
    // A RUN terminal count only pulses when RUN is kept, so no pulse ever
    // lands in LOAD, PAUSE-entry or HALT.
    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (run_rel)       state_d = ST_RUN;
                else if (step_rel) state_d = ST_PAUSE;
            end
            ST_RUN: begin
                if (run_rel)       state_d = ST_LOAD;
                else if (i_halt)   state_d = ST_HALT;
                else if (step_rel) state_d = ST_PAUSE;
                else               en_d    = terminal;
            end
            ST_PAUSE: begin
                if (run_rel)       state_d = ST_RUN;
                else if (i_halt)   state_d = ST_HALT;
                else if (step_rel) en_d    = 1'b1;
            end
            ST_HALT: begin
                if (run_rel)       state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Pulse counter: cleared on RUN entry, counts while in RUN, holds elsewhere.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ST_RUN && state_q != ST_RUN)
            cnt_d = '0;
        else if (state_q == ST_RUN)
            cnt_d = cnt_q + 1'b1;
    end

    // Load addressing: saturates at the last location instead of wrapping.
    always_comb begin
        addr_d = addr_q;
        full_d = full_q;
        if (state_d == ST_LOAD && state_q != ST_LOAD) begin
            addr_d = '0;
            full_d = 1'b0;
        end else if (we) begin
            if (addr_q == ADDR_MAX) full_d = 1'b1;
            else                    addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_LOAD;
            run_prev_q  <= 1'b0;
            step_prev_q <= 1'b0;
            addr_q      <= '0;
            full_q      <= 1'b0;
            cnt_q       <= '0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_prev_q  <= i_run_btn;
            step_prev_q <= i_step_btn;
            addr_q      <= addr_d;
            full_q      <= full_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
        end
    end

    assign o_on         = (state_q != ST_LOAD);
    assign o_state      = state_q;
    assign o_halted     = (state_q == ST_HALT);
    assign o_instr_addr = addr_q;
    assign o_instr_we   = we;
    assign o_control_en = en_q;
    assign o_mem_full   = full_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed-vector bench for cpu_run_ctrl with a small
// address space and a short pulse counter so saturation and pulse periods
// are reached in a few cycles.
module tb_cpu_run_ctrl;

    localparam int AW = 2;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run_btn;
    logic          step_btn;
    logic          rx_dv;
    logic          halt;
    logic [1:0]    rate_sel;
    logic          on;
    logic [1:0]    state;
    logic [AW-1:0] addr;
    logic          we;
    logic          ctrl_en;
    logic          full;
    logic          halted;

    int n_vec = 0;
    int n_err = 0;
    int n;
    int pulses;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .ADDR_WIDTH (AW),
        .PULSE_WIDTH(PW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_run_btn   (run_btn),
        .i_step_btn  (step_btn),
        .i_rx_dv     (rx_dv),
        .i_halt      (halt),
        .i_rate_sel  (rate_sel),
        .o_on        (on),
        .o_state     (state),
        .o_instr_addr(addr),
        .o_instr_we  (we),
        .o_control_en(ctrl_en),
        .o_mem_full  (full),
        .o_halted    (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic release_run;
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        tick();
    endtask

    task automatic release_step;
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        tick();
    endtask

    // One-cycle rx strobe; checks the combinational write enable mid-cycle.
    task automatic strobe(input logic [31:0] exp_we);
        rx_dv = 1'b1;
        #1;
        chk("instr_we", 32'(we), exp_we);
        tick();
        rx_dv = 1'b0;
    endtask

    // Cycles until the next control_en pulse (bounded).
    task automatic wait_pulse(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!ctrl_en && cycles < 200);
    endtask

    initial begin
        rst      = 1'b1;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        rx_dv    = 1'b0;
        halt     = 1'b0;
        rate_sel = 2'd0;
        tick();
        tick();
        chk("rst_state",  32'(state),   0);
        chk("rst_on",     32'(on),      0);
        chk("rst_addr",   32'(addr),    0);
        chk("rst_we",     32'(we),      0);
        chk("rst_en",     32'(ctrl_en), 0);
        chk("rst_full",   32'(full),    0);
        chk("rst_halted", 32'(halted),  0);
        rst = 1'b0;
        tick();

        // Three loads: address walks 0 -> 3, CPU stays off.
        for (int i = 0; i < 3; i++) begin
            chk("load_addr_pre", 32'(addr), 32'(i));
            strobe(1);
            chk("load_addr_post", 32'(addr), 32'(i + 1));
            chk("load_en", 32'(ctrl_en), 0);
            chk("load_on", 32'(on), 0);
        end

        // Fourth write fills the last location; fifth is dropped.
        strobe(1);
        chk("fill_addr", 32'(addr), 3);
        chk("fill_full", 32'(full), 1);
        strobe(0);
        chk("drop_addr", 32'(addr), 3);
        chk("drop_full", 32'(full), 1);

        // Run twice: RUN keeps the address, back to LOAD clears it.
        release_run();
        chk("run1_state", 32'(state), 1);
        chk("run1_on",    32'(on),    1);
        chk("run1_addr",  32'(addr),  3);
        release_run();
        chk("reload_state", 32'(state), 0);
        chk("reload_addr",  32'(addr),  0);
        chk("reload_full",  32'(full),  0);
        strobe(1);
        chk("reload_wr", 32'(addr), 1);

        // Free-running pulses: period 16 at rate 0, then 4 at rate 2.
        release_run();
        chk("run_state", 32'(state), 1);
        chk("run_entry_en", 32'(ctrl_en), 0);
        wait_pulse(n);
        chk("first_pulse", 32'(n), 16);
        wait_pulse(n);
        chk("period16", 32'(n), 16);
        rate_sel = 2'd2;
        wait_pulse(n);
        chk("period4_a", 32'(n), 4);
        wait_pulse(n);
        chk("period4_b", 32'(n), 4);

        // Pause: silent, rx ignored, one pulse per step release.
        release_step();
        chk("pause_state", 32'(state), 2);
        chk("pause_entry_en", 32'(ctrl_en), 0);
        strobe(0);
        chk("pause_rx_addr", 32'(addr), 1);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ctrl_en) pulses++;
        end
        chk("pause_quiet", 32'(pulses), 0);
        rate_sel = 2'd0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            release_step();
            if (ctrl_en) pulses++;
            tick();
            chk("step_width", 32'(ctrl_en), 0);
            chk("step_state", 32'(state), 2);
        end
        chk("step_pulses", 32'(pulses), 3);

        // Resume: counter restarts, so the first pulse is a full period away.
        release_run();
        chk("resume_state", 32'(state), 1);
        wait_pulse(n);
        chk("resume_pulse", 32'(n), 16);

        // Halt on the terminal-count cycle suppresses that pulse.
        repeat (15) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_en",     32'(ctrl_en), 0);
        chk("halt_halted", 32'(halted),  1);
        chk("halt_state",  32'(state),   3);
        chk("halt_on",     32'(on),      1);
        release_step();
        chk("halt_step_state", 32'(state),   3);
        chk("halt_step_en",    32'(ctrl_en), 0);
        release_run();
        chk("halt_exit_state", 32'(state), 0);
        chk("halt_exit_addr",  32'(addr),  0);

        // Simultaneous releases: run wins.
        run_btn  = 1'b1;
        step_btn = 1'b1;
        tick();
        run_btn  = 1'b0;
        step_btn = 1'b0;
        tick();
        chk("both_rel_state", 32'(state), 1);

        // Asynchronous reset during a pulse.
        wait_pulse(n);
        chk("pre_rst_pulse", 32'(n), 16);
        rst = 1'b1;
        #1;
        chk("arst_en",     32'(ctrl_en), 0);
        chk("arst_state",  32'(state),   0);
        chk("arst_on",     32'(on),      0);
        chk("arst_addr",   32'(addr),    0);
        chk("arst_full",   32'(full),    0);
        chk("arst_halted", 32'(halted),  0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_state", 32'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
